// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h8000_0000;
  localparam int DW_OFF_W = 3;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the memory port of the arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 12);
  logic if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_resp_valid;
  logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [7:0] d_req_wstrb;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0] mem_wstrb;
  modport slave(
    input if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb, mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master(
    output if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb, mem_rdata,
    input if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
    input mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on contention the requester not granted last wins
module rr_arbiter2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       lastGnt,
  output logic [1:0] gnt
);
  assign gnt = (req == 2'b11) ? ((lastGnt == REQ_IF) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between instruction fetch and data load/store,
// one outstanding transaction at a time.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W = 12,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  arbState state;
  logic lastGnt, owner, weL, hiWord, hs, winner;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic [63:0] reqAddr;
  logic [ADDR_W-1:0] memIdx;
  rr_arbiter2 u_rr (.req({bus.d_req_valid, bus.if_req_valid}), .lastGnt(lastGnt), .gnt(gnt));
  assign bus.if_req_ready = (state == IDLE) && gnt[REQ_IF];
  assign bus.d_req_ready = (state == IDLE) && gnt[REQ_D];
  assign hs = (state == IDLE) && (gnt != 2'b00);
  assign winner = gnt[REQ_D];
  assign reqAddr = winner ? bus.d_req_addr : bus.if_req_addr;
  // Bits above the window fall off here, so out-of-range addresses alias.
  assign memIdx = ADDR_W'((reqAddr - BASE_ADDR) >> DW_OFF_W);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      lastGnt <= REQ_IF;
      owner <= REQ_IF;
      weL <= 1'b0;
      hiWord <= 1'b0;
      cnt <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.if_resp_valid <= 1'b0;
      bus.if_resp_data <= '0;
      bus.d_resp_valid <= 1'b0;
      bus.d_resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          state <= ISSUE;
          lastGnt <= winner;
          owner <= winner;
          weL <= winner && bus.d_req_we;
          hiWord <= reqAddr[2];
          bus.mem_en <= 1'b1;
          bus.mem_we <= winner && bus.d_req_we;
          bus.mem_addr <= memIdx;
          bus.mem_wdata <= winner ? bus.d_req_wdata : '0;
          bus.mem_wstrb <= winner ? bus.d_req_wstrb : '0;
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= CW'(MEM_LATENCY);
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.mem_addr <= '0;
          bus.mem_wdata <= '0;
          bus.mem_wstrb <= '0;
        end
        WAIT: if (cnt == CW'(1)) begin
          state <= RESP;
          bus.if_resp_valid <= owner == REQ_IF;
          bus.if_resp_data <= (owner == REQ_IF) ? (hiWord ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]) : '0;
          bus.d_resp_valid <= owner == REQ_D;
          bus.d_resp_data <= (owner == REQ_D && !weL) ? bus.mem_rdata : '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
        RESP: begin
          state <= IDLE;
          bus.if_resp_valid <= 1'b0;
          bus.if_resp_data <= '0;
          bus.d_resp_valid <= 1'b0;
          bus.d_resp_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single synchronous memory between the instruction-fetch requester and the data load/store requester.
- Two-way round-robin arbiter with one outstanding memory transaction.
- Valid/ready request handshake and a single-cycle response pulse per requester.
- Sits between the multi-cycle core FSM (FETCH_INSTR / EXECUTE) and the unified instruction/data RAM.

Parameters:
MEM_LATENCY, 1, cycles from mem_en cycle to the cycle mem_rdata is valid (>=1)
ADDR_W, 12, doubleword index width of memory port
BASE_ADDR, 64'h80000000, physical address mapped to memory index 0

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  64  fetch byte address, 4-byte aligned
if_resp_valid  out  1  fetch data valid, one-cycle pulse
if_resp_data  out  32  fetched instruction word
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  64  data byte address, 8-byte aligned doubleword
d_req_we  in  1  1=store, 0=load
d_req_wdata  in  64  store data
d_req_wstrb  in  8  store byte enables
d_resp_valid  out  1  load data / store ack, one-cycle pulse
d_resp_data  out  64  load doubleword; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  doubleword index
mem_wdata  out  64  write data
mem_wstrb  out  8  byte enables
mem_rdata  in  64  read data

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (reset==0 at posedge):
  - state=IDLE, last_gnt=IF, counter=0, no transaction pending.
  - All *_resp_valid, mem_en, mem_we = 0; resp data = 0.
  - Reset mid-transaction drops it: no response pulse is ever produced for it.
- IDLE:
  - *_req_ready are combinational, high only in IDLE, for the granted requester only.
  - Only one requester is granted.
  - Round-robin rule: if both are valid, grant the one not equal to last_gnt; otherwise grant the sole valid one.
  - On handshake (valid&&ready) at cycle T:
    - Latch requester id, mem_addr = (addr-BASE_ADDR)[ADDR_W+2:3], we (forced 0 for fetch), wdata, wstrb, addr[2].
    - Update last_gnt; go to ISSUE.
- ISSUE (cycle T+1):
  - mem_en=1 for exactly this cycle; mem_we = latched we.
  - mem_addr/mem_wdata/mem_wstrb driven from latches.
  - Load counter; go to WAIT.
- WAIT:
  - Lasts exactly MEM_LATENCY cycles (T+2 .. T+1+MEM_LATENCY).
  - In its final cycle, register mem_rdata; go to RESP.
- RESP (cycle T+2+MEM_LATENCY):
  - Pulse the owner's resp_valid for one cycle; go to IDLE.
  - Fetch data: mem_rdata[63:32] if latched addr[2]==1, else [31:0].
  - Data: full 64 bits; stores return 0.
- Timing:
  - Accept-to-response latency = MEM_LATENCY+2 cycles.
  - Earliest next accept is cycle T+3+MEM_LATENCY.
- Request rules:
  - Requests arriving while not IDLE see ready=0.
  - Requesters hold valid and payload stable until ready.
  - Dropping valid before ready is legal; nothing is recorded.
- Address handling:
  - Address bits above the window are discarded (aliasing); no error signalling.
  - Unaligned addresses: low bits are ignored.
- mem_* outputs are 0 outside ISSUE.
- Counter width is $clog2(MEM_LATENCY+1).

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - requester id constants REQ_IF=0, REQ_D=1
  - BASE_ADDR default, doubleword byte-offset width 3
- One sub-module: rr_arbiter2.
  - Inputs: two request bits, last_gnt. Output: one-hot grant.
  - Purely combinational; last_gnt register lives in mem_arbiter.

Test Plan:
1. Fetch read: MEM_LATENCY=1, mem[0]=64'hAAAA_BBBB_1111_2222, if_req addr 0x80000004 accepted at T -> mem_en only at T+1 with mem_addr=0; if_resp_valid only at T+3 with if_resp_data=32'hAAAABBBB.
2. Data store then load: store addr 0x80000010, wdata=64'h0123456789ABCDEF, wstrb=8'h0F -> mem_we=1, mem_addr=2, d_resp_valid pulse with data 0; subsequent load returns memory model's byte-merged value 64'hXXXXXXXX89ABCDEF per model contents.
3. Contention: both valid continuously from reset -> grants alternate D, IF, D, IF; each grant separated by MEM_LATENCY+3 cycles; no double grant in any cycle.
4. Latency sweep: MEM_LATENCY=3 -> resp_valid exactly 5 cycles after handshake; mem_en high exactly 1 cycle per transaction.
5. Reset mid-WAIT: reset low for one cycle during WAIT -> next cycle state IDLE, no resp_valid ever for dropped request; next request serviced normally with last_gnt=IF tie-break (data wins).
6. Non-IDLE request: d_req_valid asserted during ISSUE/WAIT/RESP -> d_req_ready=0 until IDLE, then accepted.
